// File: rtl/safe_region_ctrl_if.sv
// Requester-side handshake bundle for the safe-region stack controller.
// Two requesters (r0 = call/return hook, r1 = trap/context handler) share one controller.
interface safe_region_ctrl_if;
    logic        r0_valid;
    logic        r0_ready;
    logic [1:0]  r0_op;
    logic [31:0] r0_data;
    logic        r0_resp_valid;
    logic        r0_resp_err;
    logic        r0_resp_mismatch;
    logic [31:0] r0_resp_data;

    logic        r1_valid;
    logic        r1_ready;
    logic [1:0]  r1_op;
    logic [31:0] r1_data;
    logic        r1_resp_valid;
    logic        r1_resp_err;
    logic        r1_resp_mismatch;
    logic [31:0] r1_resp_data;

    modport master (
        output r0_valid, r0_op, r0_data, r1_valid, r1_op, r1_data,
        input  r0_ready, r0_resp_valid, r0_resp_err, r0_resp_mismatch, r0_resp_data,
        input  r1_ready, r1_resp_valid, r1_resp_err, r1_resp_mismatch, r1_resp_data
    );

    modport slave (
        input  r0_valid, r0_op, r0_data, r1_valid, r1_op, r1_data,
        output r0_ready, r0_resp_valid, r0_resp_err, r0_resp_mismatch, r0_resp_data,
        output r1_ready, r1_resp_valid, r1_resp_err, r1_resp_mismatch, r1_resp_data
    );
endinterface

// File: rtl/safe_region_ctrl.sv
// Round-robin sequencer in front of the safe-region stack store: tracks occupancy,
// blocks overflow/underflow, checks popped return values and drains the store after reset.
//
// state | meaning
// INIT  | drain store with DEPTH pops so its index is 0
// IDLE  | arbitrate and accept one request
// ISSUE | drive the push/pop onto the store, update count
// WAIT  | popped word registers in the store
// RESP  | one-cycle response pulse to the owning requester
module safe_region_ctrl #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 9
) (
    input  logic                clk,
    input  logic                rst,
    safe_region_ctrl_if.slave   req,
    output logic                sr_enop,
    output logic [7:0]          sr_op,
    output logic [31:0]         sr_wdata,
    input  logic [31:0]         sr_rdata,
    output logic [CNT_W-1:0]    count,
    output logic                fault,
    input  logic                clr_fault
);
    localparam logic [1:0]       OP_PUSH   = 2'b01;
    localparam logic [1:0]       OP_POP    = 2'b10;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] init_cnt;
    logic             rr_ptr;
    logic             owner;
    logic [1:0]       op_q;
    logic [31:0]      data_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    logic             gnt0, gnt1, accept, acc_err;
    logic [1:0]       acc_op;
    logic [31:0]      acc_data;
    logic             mismatch;

    // rr_ptr = 0 favours r0 when both requesters are valid
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state == S_IDLE) begin
            gnt0 = req.r0_valid && (!req.r1_valid || !rr_ptr);
            gnt1 = req.r1_valid && (!req.r0_valid ||  rr_ptr);
        end
        accept   = gnt0 || gnt1;
        acc_op   = gnt1 ? req.r1_op   : req.r0_op;
        acc_data = gnt1 ? req.r1_data : req.r0_data;
        acc_err  = !(((acc_op == OP_PUSH) && (count < DEPTH_C)) ||
                     ((acc_op == OP_POP)  && (count != '0)));
        mismatch = !err_q && (op_q == OP_POP) && (rdata_q != data_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (init_cnt == '0) state_nxt = S_IDLE;
            S_IDLE:  if (accept) state_nxt = acc_err ? S_RESP : S_ISSUE;
            S_ISSUE: state_nxt = (op_q == OP_POP) ? S_WAIT : S_RESP;
            S_WAIT:  state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt <= INIT_LAST;
            rr_ptr   <= 1'b0;
            owner    <= 1'b0;
            op_q     <= 2'b00;
            data_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            count    <= '0;
            fault    <= 1'b0;
        end else begin
            if ((state == S_INIT) && (init_cnt != '0)) init_cnt <= init_cnt - 1'b1;
            if (accept) begin
                owner   <= gnt1;
                op_q    <= acc_op;
                data_q  <= acc_data;
                err_q   <= acc_err;
                rdata_q <= '0;
                if (req.r0_valid && req.r1_valid) rr_ptr <= ~rr_ptr;
            end
            if (state == S_ISSUE) count <= (op_q == OP_PUSH) ? count + 1'b1 : count - 1'b1;
            if (state == S_WAIT)  rdata_q <= sr_rdata;
            // a setting response wins over a simultaneous clear
            if ((state == S_RESP) && (err_q || mismatch)) fault <= 1'b1;
            else if (clr_fault)                          fault <= 1'b0;
        end
    end

    always_comb begin
        sr_enop              = 1'b0;
        sr_op                = 8'd0;
        sr_wdata             = '0;
        req.r0_ready         = gnt0;
        req.r1_ready         = gnt1;
        req.r0_resp_valid    = 1'b0;
        req.r0_resp_err      = 1'b0;
        req.r0_resp_mismatch = 1'b0;
        req.r0_resp_data     = '0;
        req.r1_resp_valid    = 1'b0;
        req.r1_resp_err      = 1'b0;
        req.r1_resp_mismatch = 1'b0;
        req.r1_resp_data     = '0;
        case (state)
            S_INIT: begin
                // held quiet while reset is asserted so the store sees no ops
                sr_enop = !rst;
                sr_op   = rst ? 8'd0 : 8'd2;
            end
            S_ISSUE: begin
                sr_enop  = 1'b1;
                sr_op    = {6'b0, op_q};
                sr_wdata = (op_q == OP_PUSH) ? data_q : '0;
            end
            S_RESP: begin
                if (owner) begin
                    req.r1_resp_valid    = 1'b1;
                    req.r1_resp_err      = err_q;
                    req.r1_resp_mismatch = mismatch;
                    req.r1_resp_data     = rdata_q;
                end else begin
                    req.r0_resp_valid    = 1'b1;
                    req.r0_resp_err      = err_q;
                    req.r0_resp_mismatch = mismatch;
                    req.r0_resp_data     = rdata_q;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: doc/safe_region_ctrl.md
Name: safe_region_ctrl

Overview:
- Sequencer and arbiter in front of the safe-region stack memory (1-cycle-registered push/pop store, op codes 1 = push, 2 = pop, no reset, no full/empty flags).
- Shares the store between two requesters: r0 = core call/return hook, r1 = trap/context handler. Arbitration is round-robin.
- Owns occupancy tracking, overflow/underflow detection and return-value checking.
- On every reset it drains the store so the store's internal index is known to be 0.

Parameters:
- DEPTH, 256: stack entries; must equal the store's size.
- CNT_W, 9: occupancy counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- rN_valid  in  1  request valid (N = 0, 1)
- rN_ready  out  1  request accepted this cycle
- rN_op  in  2  01 = push, 10 = pop-and-check; 00 and 11 are illegal
- rN_data  in  32  push data, or expected value for a pop
- rN_resp_valid  out  1  one-cycle response pulse
- rN_resp_err  out  1  overflow, underflow or illegal op
- rN_resp_mismatch  out  1  popped value differs from rN_data
- rN_resp_data  out  32  popped value; 0 for push
- sr_enop  out  1  store operation enable
- sr_op  out  8  store op code
- sr_wdata  out  32  store write data
- sr_rdata  in  32  store read data (registered by the store)
- count  out  CNT_W  current occupancy
- fault  out  1  sticky error/mismatch flag
- clr_fault  in  1  synchronous clear of fault

Behaviour:
- Reset values:
  - all rN_ready, rN_resp_* = 0; sr_enop = 0; sr_op = 0; sr_wdata = 0.
  - count = 0, fault = 0, round-robin pointer = r0, state = INIT.
  - An assertion mid-operation aborts the operation immediately; no response is produced.
- INIT:
  - Drives sr_enop = 1, sr_op = 2 for exactly DEPTH consecutive cycles (pop at store index 0 is a no-op), guaranteeing store index = 0.
  - rN_ready = 0 throughout; then moves to IDLE.
- IDLE:
  - rN_ready is combinational: high for the single granted requester in the cycle it is accepted.
  - Grant when only one requester is valid: that requester.
  - Grant when both are valid: the one the pointer favours; the pointer then flips to the other requester.
  - Op and data are captured at acceptance.
- Legal push, count < DEPTH:
  - Next state ISSUE: sr_enop = 1, sr_op = 1, sr_wdata = captured data, count+1.
  - Next state RESP: resp_valid with err = 0, mismatch = 0, data = 0.
  - Accept-to-response latency is 2 cycles.
- Legal pop, count > 0:
  - ISSUE: sr_enop = 1, sr_op = 2, count−1.
  - WAIT: one cycle for sr_rdata to register.
  - RESP: resp_data = sr_rdata; mismatch = (sr_rdata != captured data).
  - Latency is 3 cycles.
- Error cases (push at count == DEPTH, pop at count == 0, op 00 or 11):
  - No store access (sr_enop stays 0) and count is unchanged.
  - Goes directly to RESP with err = 1 (latency 1 cycle), resp_data = 0, mismatch = 0.
- RESP:
  - Pulses only the owning requester's resp_valid for one cycle, then returns to IDLE.
  - The next accept can occur in the cycle after RESP.
  - Responses have no back-pressure.
- sr_enop is high only in ISSUE and INIT; sr_op = 0 otherwise.
- fault:
  - Set on any response with err or mismatch.
  - clr_fault clears it; a set event in the same cycle as clr_fault wins.
- count never wraps; it saturates by rule because errors block the store access.

Test Plan:
- Reset release: count for sr_enop & sr_op == 2 pulses → exactly 256 (DEPTH); rN_ready stays 0 until INIT ends.
- r0 push 0x0000_1234, then r0 pop expecting 0x0000_1234 → push response at +2 (err 0); pop response at +3 with data 0x1234, mismatch 0; count 1 → 0.
- Push 0xAAAA_0001, pop expecting 0xBBBB_0002 → mismatch = 1, resp_data = 0xAAAA_0001, fault = 1; clr_fault → fault = 0.
- r0 and r1 both valid with continuous pushes → grants alternate r0, r1, r0, …; store holds data in grant order; pops return it in LIFO order.
- 256 pushes, then a 257th push → err = 1, no sr_enop, count = 256. From empty, a pop → err = 1, count = 0.
- Assert rst during a pop's WAIT cycle → no resp_valid; count = 0; INIT replays 256 drain pops; a subsequent push/pop round-trips correctly.
